// File: rtl/serial_subtractor_8bit.sv
// Bit-serial 8-bit unsigned subtractor (a - b - borrow_in), LSB first, one bit per clock.
// A start/busy/done handshake lets a controller time-multiplex the block.
module serial_subtractor_8bit (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       borrow_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] diff,
   output logic       underflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t     state_r;
   logic [7:0] a_sr_r;
   logic [7:0] b_sr_r;
   logic [7:0] work_sr_r;
   logic       brw_r;
   logic [2:0] cnt_r;
   logic       d_s;
   logic       brw_next_s;

   function automatic logic full_sub_diff(input logic x, input logic y, input logic bi);
      return x ^ y ^ bi;
   endfunction

   function automatic logic full_sub_borrow(input logic x, input logic y, input logic bi);
      return (~x & y) | (~(x ^ y) & bi);
   endfunction

   // One-bit full-subtractor slice on the current LSBs.
   always_comb begin
      d_s        = full_sub_diff(a_sr_r[0], b_sr_r[0], brw_r);
      brw_next_s = full_sub_borrow(a_sr_r[0], b_sr_r[0], brw_r);
   end

   // Control FSM, serial datapath and registered handshake/result outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r   <= IDLE;
         a_sr_r    <= 8'h00;
         b_sr_r    <= 8'h00;
         work_sr_r <= 8'h00;
         brw_r     <= 1'b0;
         cnt_r     <= 3'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         diff      <= 8'h00;
         underflow <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  a_sr_r  <= a;
                  b_sr_r  <= b;
                  brw_r   <= borrow_in;
                  cnt_r   <= 3'd0;
                  state_r <= SHIFT;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            end
            SHIFT: begin
               work_sr_r <= {d_s, work_sr_r[7:1]};
               a_sr_r    <= {1'b0, a_sr_r[7:1]};
               b_sr_r    <= {1'b0, b_sr_r[7:1]};
               brw_r     <= brw_next_s;
               cnt_r     <= cnt_r + 3'd1;
               // Last bit: publish the result on the same edge the final bit is formed.
               if (cnt_r == 3'd7) begin
                  diff      <= {d_s, work_sr_r[7:1]};
                  underflow <= brw_next_s;
                  state_r   <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  state_r   <= SHIFT;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Scoreboard bench for serial_subtractor_8bit: directed vectors push expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_serial_subtractor_8bit;

   logic       clk;
   logic       n_rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       borrow_in;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       underflow;

   typedef struct {
      logic [7:0] d;
      logic       u;
      int         c;
   } exp_t;

   exp_t q[$];
   int   n_cmp;
   int   n_err;
   int   cyc;
   logic [7:0] prev_diff;
   logic       prev_uf;

   serial_subtractor_8bit dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .borrow_in (borrow_in),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: pops one expectation per done pulse; results must not move during SHIFT.
   always @(negedge clk) begin
      if (n_rst) begin
         if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("diff", 32'(diff), 32'(e.d));
               chk("underflow", 32'(underflow), 32'(e.u));
               chk("done_cycle", 32'(cyc), 32'(e.c));
            end
         end
         if (busy) begin
            chk("diff_stable", 32'(diff), 32'(prev_diff));
            chk("uf_stable", 32'(underflow), 32'(prev_uf));
         end
      end
      prev_diff = diff;
      prev_uf   = underflow;
   end

   // Launch one operation and follow it to completion; optional input scrambling / stray start.
   task automatic op(input logic [7:0] aa, input logic [7:0] bb, input logic bi,
                     input logic [7:0] ed, input logic eu,
                     input bit scramble, input bit restart);
      exp_t e;
      @(negedge clk);
      a = aa; b = bb; borrow_in = bi; start = 1'b1;
      e.d = ed; e.u = eu; e.c = cyc + 9;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("busy_during_shift", 32'(busy), 32'd1);
         chk("no_done_during_shift", 32'(done), 32'd0);
         if (scramble) begin
            a = 8'hAA; b = 8'h55; borrow_in = ~bi;
         end
         start = (restart && i == 3) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_low_in_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_single_cycle", 32'(done), 32'd0);
      chk("idle_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      exp_t e;
      n_cmp = 0; n_err = 0; cyc = 0;
      n_rst = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; borrow_in = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_uf", 32'(underflow), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
      op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
      op(8'h3C, 8'h0A, 1'b0, 8'h32, 1'b0, 1'b0, 1'b1);
      repeat (12) @(negedge clk);

      // Back-to-back: start held through the first DONE cycle.
      @(negedge clk);
      a = 8'h80; b = 8'h7F; borrow_in = 1'b0; start = 1'b1;
      e.d = 8'h01; e.u = 1'b0; e.c = cyc + 9;
      q.push_back(e);
      repeat (9) @(negedge clk);
      chk("b2b_first_done", 32'(done), 32'd1);
      a = 8'h7F; b = 8'h80;
      e.d = 8'hFF; e.u = 1'b1; e.c = cyc + 9;
      q.push_back(e);
      @(negedge clk);
      chk("b2b_no_gap_busy", 32'(busy), 32'd1);
      repeat (8) @(negedge clk);
      chk("b2b_second_done", 32'(done), 32'd1);
      start = 1'b0;
      @(negedge clk);
      chk("b2b_no_third", 32'(busy), 32'd0);

      // Reset mid-operation, between edges at bit 4.
      @(negedge clk);
      a = 8'h0F; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_uf", 32'(underflow), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("idle_after_abort", 32'({busy, done}), 32'd0);
      end

      op(8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor_8bit.md
# serial_subtractor_8bit

Bit-serial 8-bit unsigned subtractor computing a - b - borrow_in, one bit per clock, LSB first, using a single registered borrow. It is the inverse-direction arithmetic companion to the 8-bit ripple-carry adder in the same datapath library. It trades latency for area and adds a start/busy/done handshake, so it can be time-multiplexed under a controller.

## Interface
Parameters: none (width fixed at 8).
- clk  input  1  system clock, all state updates on rising edge
- n_rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled high in IDLE or DONE launches an operation
- a  input  8  minuend, captured on the accepting edge only
- b  input  8  subtrahend, captured on the accepting edge only
- borrow_in  input  1  borrow into bit 0, captured on the accepting edge only
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  single-cycle pulse: result valid
- diff  output  8  registered difference, updated only at completion
- underflow  output  1  registered borrow out of bit 7 (a < b + borrow_in), updated only at completion

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset (n_rst low, asynchronous) forces all of the following:
  - state = IDLE
  - busy = 0, done = 0, diff = 0x00, underflow = 0
  - internal operand and working shift registers = 0, borrow register = 0, bit counter = 0
- IDLE or DONE with start = 1 at an edge:
  - load a_sr <= a, b_sr <= b, brw <= borrow_in, cnt <= 0
  - go to SHIFT
- IDLE with start = 0: stay in IDLE. DONE with start = 0: return to IDLE.
- SHIFT, each edge processes one bit:
  - d = a_sr[0] ^ b_sr[0] ^ brw
  - brw <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw)
  - work_sr <= {d, work_sr[7:1]}
  - a_sr and b_sr shift right by one
  - cnt <= cnt + 1
- On the SHIFT edge where cnt == 7:
  - diff <= {d, work_sr[7:1]} and underflow <= borrow computed for bit 7, on the same edge
  - go to DONE
- start is ignored while in SHIFT. The operation in flight is not disturbed, and a, b and borrow_in are not sampled.
- diff and underflow hold their values until the next completion or reset. They do not change during SHIFT.
- Arithmetic is modulo 256: diff = (a - b - borrow_in) mod 256, underflow = 1 iff a < b + borrow_in, evaluated as unsigned 9-bit values.
- busy = (state == SHIFT); done = (state == DONE). Both are decoded from the state register and are glitch-free.

## Timing
- Let edge E be the edge where start is accepted.
- Edges E+1 .. E+8 process bits 0..7, with busy = 1 from after E through E+8.
- After edge E+8: state = DONE and done = 1 for exactly one cycle. diff and underflow are valid from this cycle onward.
- Latency: 8 clocks from the accepting edge to the done cycle.
- Throughput, back-to-back: start held high during the DONE cycle is accepted at the edge ending DONE. busy then rises with no idle gap, giving one result every 9 cycles.
- Reset asserted mid-SHIFT aborts immediately:
  - diff and underflow return to 0
  - no done pulse is produced
  - after reset release the block waits in IDLE for a new start

## Test plan
- Basic case: after reset, a=0x50, b=0x20, borrow_in=0, start pulsed one cycle. Required: busy high for 8 cycles, then done for one cycle, diff=0x30, underflow=0.
- Wrap-around: a=0x00, b=0x01, borrow_in=0. Required: diff=0xFF, underflow=1. Then a=0xFF, b=0xFF, borrow_in=1. Required: diff=0xFF, underflow=1.
- Borrow_in path: a=0x10, b=0x0F, borrow_in=1. Required: diff=0x00, underflow=0. Inputs changed to 0xAA/0x55 during busy must not affect the result.
- Ignored start: pulse start again 3 cycles into SHIFT. Required: still exactly one done pulse 8 cycles after the original accept, and no second operation.
- Back-to-back: start held high continuously with a=0x80, b=0x7F, then a=0x7F, b=0x80 presented in the DONE cycle. Required: first diff=0x01/underflow=0, second diff=0xFF/underflow=1, done pulses 9 cycles apart.
- Reset mid-operation: drop n_rst asynchronously at bit 4, between edges. Required: busy, done, diff and underflow go to 0 immediately, with no done afterwards until a new start.
